// File: rtl/uart_command_sequencer.sv
// Serialises one controller command (opcode + payload bytes) into back-to-back
// UART frames: start, data LSB-first, parity, stop, then an idle-high gap.
module uart_command_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESCALE    = 32,
  parameter int GAP_CYCLES  = 3,
  parameter int PARITY_TYPE = 0
) (
  input  logic                  UART_clk,
  input  logic                  reset,
  input  logic                  command_valid,
  output logic                  command_ready,
  input  logic [1:0]            command_type,
  input  logic [DATA_WIDTH-1:0] field_0,
  input  logic [DATA_WIDTH-1:0] field_1,
  input  logic [DATA_WIDTH-1:0] field_2,
  output logic                  serial_data_out,
  output logic                  frame_sent,
  output logic                  busy
);

  // state  | meaning
  // IDLE   | line high, ready for a command
  // START  | start bit (0) for PRESCALE cycles
  // DATA   | payload bits LSB first, PRESCALE cycles each
  // PARITY | parity bit for PRESCALE cycles
  // STOP   | stop bit (1); frame_sent in its last cycle
  // GAP    | idle-high spacing after each frame, GAP_CYCLES long
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic          PAR_ODD    = (PARITY_TYPE != 0);

  state_t                state, state_n;
  logic [PW-1:0]         presc, presc_n;
  logic [BW-1:0]         bit_idx, bit_n;
  logic [1:0]            frame_idx, frame_n;
  logic [GW-1:0]         gap_cnt, gap_n;
  logic [1:0]            type_q;
  logic [DATA_WIDTH-1:0] f0_q, f1_q, f2_q;
  logic                  accept;
  logic [1:0]            last_idx;
  logic                  presc_last;
  logic                  last_frame;
  logic [DATA_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0] frame_byte;
  logic                  line_n;

  assign command_ready = (state == S_IDLE);
  assign busy          = !command_ready;
  assign frame_sent    = (state == S_STOP) && presc_last;
  assign presc_last    = (presc == PRESC_LAST);
  assign last_frame    = (frame_idx == last_idx);

  always_comb begin
    last_idx = 2'd1;
    opcode   = DATA_WIDTH'(8'hAA);
    case (type_q)
      2'd0: begin last_idx = 2'd2; opcode = DATA_WIDTH'(8'hAA); end
      2'd1: begin last_idx = 2'd1; opcode = DATA_WIDTH'(8'hBB); end
      2'd2: begin last_idx = 2'd3; opcode = DATA_WIDTH'(8'hCC); end
      default: begin last_idx = 2'd1; opcode = DATA_WIDTH'(8'hDD); end
    endcase
  end

  always_comb begin
    state_n = state;
    presc_n = presc;
    bit_n   = bit_idx;
    frame_n = frame_idx;
    gap_n   = gap_cnt;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        if (command_valid) begin
          accept  = 1'b1;
          state_n = S_START;
          presc_n = '0;
          bit_n   = '0;
          frame_n = '0;
          gap_n   = '0;
        end
      end
      S_START: begin
        if (presc_last) begin
          state_n = S_DATA;
          presc_n = '0;
          bit_n   = '0;
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      S_DATA: begin
        if (presc_last) begin
          presc_n = '0;
          if (bit_idx == BIT_LAST) begin
            state_n = S_PARITY;
            bit_n   = '0;
          end else begin
            bit_n = bit_idx + BW'(1);
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      S_PARITY: begin
        if (presc_last) begin
          state_n = S_STOP;
          presc_n = '0;
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      S_STOP: begin
        if (presc_last) begin
          presc_n = '0;
          if (GAP_CYCLES > 0) begin
            state_n = S_GAP;
            gap_n   = '0;
          end else if (last_frame) begin
            state_n = S_IDLE;
            frame_n = '0;
          end else begin
            state_n = S_START;
            frame_n = frame_idx + 2'd1;
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_n = '0;
          if (last_frame) begin
            state_n = S_IDLE;
            frame_n = '0;
          end else begin
            state_n = S_START;
            frame_n = frame_idx + 2'd1;
          end
        end else begin
          gap_n = gap_cnt + GW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        presc_n = '0;
        bit_n   = '0;
        frame_n = '0;
        gap_n   = '0;
      end
    endcase
  end

  // Line value is computed for the state being entered so the registered
  // output lines up exactly with the FSM state it belongs to.
  always_comb begin
    frame_byte = opcode;
    case (frame_n)
      2'd0:    frame_byte = opcode;
      2'd1:    frame_byte = f0_q;
      2'd2:    frame_byte = f1_q;
      default: frame_byte = f2_q;
    endcase
    line_n = 1'b1;
    case (state_n)
      S_START:  line_n = 1'b0;
      S_DATA:   line_n = frame_byte[bit_n];
      S_PARITY: line_n = (^frame_byte) ^ PAR_ODD;
      default:  line_n = 1'b1;
    endcase
  end

  always_ff @(posedge UART_clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      presc           <= '0;
      bit_idx         <= '0;
      frame_idx       <= '0;
      gap_cnt         <= '0;
      serial_data_out <= 1'b1;
    end else begin
      state           <= state_n;
      presc           <= presc_n;
      bit_idx         <= bit_n;
      frame_idx       <= frame_n;
      gap_cnt         <= gap_n;
      serial_data_out <= line_n;
    end
  end

  always_ff @(posedge UART_clk or posedge reset) begin
    if (reset) begin
      type_q <= '0;
      f0_q   <= '0;
      f1_q   <= '0;
      f2_q   <= '0;
    end else if (accept) begin
      type_q <= command_type;
      f0_q   <= field_0;
      f1_q   <= field_1;
      f2_q   <= field_2;
    end
  end

endmodule

// File: tb/tb_uart_command_sequencer.sv
// Directed bench: dut_a uses even parity with a 3-cycle gap, dut_b odd parity
// with no gap; every line cycle of every frame is compared to hand values.
module tb_uart_command_sequencer;

  logic       clk;
  logic       reset;
  logic       valid_a, valid_b;
  logic [1:0] command_type;
  logic [7:0] field_0, field_1, field_2;
  logic       ready_a, line_a, sent_a, busy_a;
  logic       ready_b, line_b, sent_b, busy_b;

  int compared   = 0;
  int mismatched = 0;

  uart_command_sequencer #(.DATA_WIDTH(8), .PRESCALE(4), .GAP_CYCLES(3), .PARITY_TYPE(0)) dut_a (
    .UART_clk(clk), .reset(reset), .command_valid(valid_a), .command_ready(ready_a),
    .command_type(command_type), .field_0(field_0), .field_1(field_1), .field_2(field_2),
    .serial_data_out(line_a), .frame_sent(sent_a), .busy(busy_a)
  );

  uart_command_sequencer #(.DATA_WIDTH(8), .PRESCALE(4), .GAP_CYCLES(0), .PARITY_TYPE(1)) dut_b (
    .UART_clk(clk), .reset(reset), .command_valid(valid_b), .command_ready(ready_b),
    .command_type(command_type), .field_0(field_0), .field_1(field_1), .field_2(field_2),
    .serial_data_out(line_b), .frame_sent(sent_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic line_of(input int w);
    return (w != 0) ? line_b : line_a;
  endfunction
  function automatic logic sent_of(input int w);
    return (w != 0) ? sent_b : sent_a;
  endfunction
  function automatic logic busy_of(input int w);
    return (w != 0) ? busy_b : busy_a;
  endfunction
  function automatic logic ready_of(input int w);
    return (w != 0) ? ready_b : ready_a;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int w);
    chk({tag, "_line"},  line_of(w),  1'b1);
    chk({tag, "_ready"}, ready_of(w), 1'b1);
    chk({tag, "_busy"},  busy_of(w),  1'b0);
    chk({tag, "_sent"},  sent_of(w),  1'b0);
  endtask

  // Present a command at a negedge; accepted on the following posedge.
  task automatic issue(input int w, input logic [1:0] t, input logic [7:0] f0,
                       input logic [7:0] f1, input logic [7:0] f2, input bit hold);
    @(negedge clk);
    chk("issue_ready", ready_of(w), 1'b1);
    command_type = t;
    field_0 = f0;
    field_1 = f1;
    field_2 = f2;
    if (w != 0) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      valid_a = 1'b0;
      valid_b = 1'b0;
    end
    command_type = ~t;
    field_0 = ~f0;
    field_1 = ~f1;
    field_2 = ~f2;
  endtask

  // Checks every cycle of one frame plus its trailing gap (PRESCALE = 4).
  task automatic check_frame(input int w, input logic [7:0] byte_v, input logic par, input int gap);
    logic [10:0] bits;
    bits = {1'b1, par, byte_v, 1'b0};
    for (int s = 0; s < 11; s++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk($sformatf("f%02h_slot%0d_line", byte_v, s), line_of(w), bits[s]);
        chk($sformatf("f%02h_slot%0d_sent", byte_v, s), sent_of(w), (s == 10) && (c == 3));
        chk($sformatf("f%02h_slot%0d_busy", byte_v, s), busy_of(w), 1'b1);
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk($sformatf("f%02h_gap%0d_line", byte_v, g), line_of(w), 1'b1);
      chk($sformatf("f%02h_gap%0d_sent", byte_v, g), sent_of(w), 1'b0);
      chk($sformatf("f%02h_gap%0d_busy", byte_v, g), busy_of(w), 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    command_type = 2'd0;
    field_0 = 8'h00;
    field_1 = 8'h00;
    field_2 = 8'h00;
    repeat (2) @(negedge clk);
    chk_idle("rst_a", 0);
    chk_idle("rst_b", 1);
    reset = 1'b0;

    // Reset during DATA bit 3 of a write (cycles 17..20 after accept)
    issue(0, 2'd0, 8'h05, 8'h3C, 8'h00, 1'b0);
    repeat (14) @(negedge clk);
    chk("pre_rst_bit2", line_a, 1'b0);
    repeat (4) @(negedge clk);
    chk("pre_rst_bit3", line_a, 1'b1);
    chk("pre_rst_busy", busy_a, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_idle("midrst", 0);
    @(negedge clk);
    reset = 1'b0;
    issue(0, 2'd1, 8'h05, 8'h00, 8'h00, 1'b0);
    check_frame(0, 8'hBB, 1'b0, 3);
    check_frame(0, 8'h05, 1'b0, 3);
    @(negedge clk);
    chk_idle("post_rst_read_done", 0);

    // Write: 3 * (44 + 3) = 141 cycles busy
    issue(0, 2'd0, 8'h05, 8'h3C, 8'h00, 1'b0);
    check_frame(0, 8'hAA, 1'b0, 3);
    check_frame(0, 8'h05, 1'b0, 3);
    check_frame(0, 8'h3C, 1'b0, 3);
    @(negedge clk);
    chk_idle("write_done", 0);

    // Read
    issue(0, 2'd1, 8'h07, 8'h00, 8'h00, 1'b0);
    check_frame(0, 8'hBB, 1'b0, 3);
    check_frame(0, 8'h07, 1'b1, 3);
    @(negedge clk);
    chk_idle("read_done", 0);

    // ALU with operands; fields are scrambled right after acceptance
    issue(0, 2'd2, 8'h0A, 8'h03, 8'h01, 1'b0);
    check_frame(0, 8'hCC, 1'b0, 3);
    check_frame(0, 8'h0A, 1'b0, 3);
    check_frame(0, 8'h03, 1'b0, 3);
    check_frame(0, 8'h01, 1'b1, 3);
    @(negedge clk);
    chk_idle("alu_done", 0);

    // Back-to-back with valid held: DD/02 then BB/00
    issue(0, 2'd3, 8'h02, 8'h00, 8'h00, 1'b1);
    command_type = 2'd1;
    field_0 = 8'h00;
    check_frame(0, 8'hDD, 1'b0, 3);
    check_frame(0, 8'h02, 1'b1, 3);
    @(negedge clk);
    chk("b2b_ready", ready_a, 1'b1);
    chk("b2b_idle_line", line_a, 1'b1);
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    field_0 = 8'hFF;
    check_frame(0, 8'hBB, 1'b0, 3);
    check_frame(0, 8'h00, 1'b0, 3);
    @(negedge clk);
    chk_idle("b2b_done", 0);

    // Odd parity, no gap
    issue(1, 2'd0, 8'h00, 8'hFF, 8'h00, 1'b0);
    check_frame(1, 8'hAA, 1'b1, 0);
    check_frame(1, 8'h00, 1'b1, 0);
    check_frame(1, 8'hFF, 1'b1, 0);
    @(negedge clk);
    chk_idle("odd_done", 1);
    chk_idle("odd_a_untouched", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_command_sequencer.md
# uart_command_sequencer

Host-side command sequencer that sits directly upstream of the system top's `serial_data_in` pin. It accepts one complete controller command per handshake: register write, register read, ALU with operands, or ALU without operands. It emits the command's opcode byte and payload bytes back-to-back as 11-bit UART frames: start, data LSB-first, parity, stop. The bit period and inter-frame gap match what the system's UART receiver samples.

## Interface
- `DATA_WIDTH`, 8, frame payload width; must be ≥ 8; opcodes are zero-extended
- `PRESCALE`, 32, `UART_clk` cycles per serial bit; must be ≥ 2
- `GAP_CYCLES`, 3, idle-high `UART_clk` cycles inserted after every stop bit; 0 is legal
- `PARITY_TYPE`, 0, 0 = even parity over data bits, 1 = odd parity

- `UART_clk`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `command_valid`  in  1  command fields valid
- `command_ready`  out  1  sequencer idle and able to accept
- `command_type`  in  2  0 = write (opcode 0xAA), 1 = read (0xBB), 2 = ALU with operands (0xCC), 3 = ALU without operands (0xDD)
- `field_0`  in  DATA_WIDTH  write: address; read: address; CC: operand A; DD: function
- `field_1`  in  DATA_WIDTH  write: data; CC: operand B; otherwise ignored
- `field_2`  in  DATA_WIDTH  CC: function; otherwise ignored
- `serial_data_out`  out  1  UART line to system top `serial_data_in`; idle high
- `frame_sent`  out  1  one-cycle pulse at the end of each frame's stop bit
- `busy`  out  1  equals `!command_ready`

## Operation
- Frame count per command type:
  - write: 3 (AA, field_0, field_1)
  - read: 2 (BB, field_0)
  - CC: 4 (CC, field_0, field_1, field_2)
  - DD: 2 (DD, field_0)
- Accept on a rising edge with `command_valid && command_ready`.
  - All fields and the type are registered at acceptance.
  - Inputs are don't-care afterwards.
- FSM states:
  - IDLE: line high, ready = 1. On accept, go to START with frame index 0.
  - START: line 0 for PRESCALE cycles.
  - DATA: bits 0..DATA_WIDTH-1, LSB first, PRESCALE cycles each.
  - PARITY: the parity bit per PARITY_TYPE, PRESCALE cycles.
  - STOP: line 1 for PRESCALE cycles. `frame_sent` pulses in the last cycle.
  - GAP: line 1 for GAP_CYCLES cycles, skipped if 0. Then go to START if frames remain, else IDLE.
- Counters:
  - prescale counter, 0..PRESCALE-1
  - bit index, 0..DATA_WIDTH-1
  - frame index, 0..3
  - gap counter
- Each counter wraps to 0 on state change.
- The frame byte is selected by frame index: opcode, field_0, field_1, field_2.
- `serial_data_out` is a registered output with no glitches.

## Timing
- Reset values:
  - `serial_data_out` = 1
  - `command_ready` = 1
  - `busy` = 0
  - `frame_sent` = 0
  - FSM in IDLE, all counters 0
- Latency:
  - The start bit drives the line in the cycle immediately after the accepting edge.
  - `command_ready` falls on that same edge.
- Frame length is (DATA_WIDTH+3)·PRESCALE cycles.
- Command length is N·((DATA_WIDTH+3)·PRESCALE + GAP_CYCLES) cycles, where N is the frame count.
- `command_ready` returns high on the edge that ends the last GAP cycle.
  - If GAP_CYCLES = 0, it returns high on the edge that ends the last STOP cycle.
  - A new command may be accepted on the very next edge, giving zero extra idle.
- `command_valid` while busy is ignored. No command is queued or dropped silently: the source must hold valid until ready.
- Reset mid-command:
  - Immediate abort.
  - Line high asynchronously.
  - Partial frame is abandoned.
  - The next command starts clean.
- Simultaneous last-GAP-cycle and `command_valid`: accept occurs only once `command_ready` is high, i.e. one edge later.

## Test plan
Each scenario runs with PRESCALE = 4, GAP_CYCLES = 3, PARITY_TYPE = 0 unless stated otherwise.

- **Reset**
  - Stimulus: assert `reset` during the DATA bit 3 of a write.
  - Required response:
    - `serial_data_out` goes 1 without a clock edge.
    - `command_ready` = 1.
    - After release, a read with field_0 = 0x05 emits exactly 2 clean frames.
- **Write**
  - Stimulus: type 0, field_0 = 0x05, field_1 = 0x3C.
  - Required response:
    - Three frames AA/05/3C with parity bits 0/0/0.
    - 3 `frame_sent` pulses.
    - `command_ready` high after 3·(44+3) = 141 cycles.
- **Read**
  - Stimulus: type 1, field_0 = 0x07.
  - Required response:
    - Frames BB (parity 0) and 07 (parity 1).
    - Bit order on the line for 0x07 is 0,1,1,1,0,0,0,0,0,1,1.
- **ALU with operands**
  - Stimulus: type 2, fields 0x0A/0x03/0x01.
  - Required response:
    - Frames CC, 0A, 03, 01.
    - Fields changed after acceptance do not alter the output.
- **Back-to-back**
  - Stimulus: DD/0x02 followed immediately by BB/0x00, with valid held high.
  - Required response:
    - Second start bit begins exactly 1 cycle after `command_ready` rises.
    - `command_valid` is ignored while busy.
- **Odd parity, no gap**
  - Stimulus: PARITY_TYPE = 1, GAP_CYCLES = 0, write 0x00/0xFF.
  - Required response:
    - Parity bits are 1 (AA), 1 (00), 1 (FF).
    - Stop bit is immediately followed by the next start bit.
